dram_port_arbiter: RTL

//  Dynamic arbiter sharing the single-port data SRAM between two requesters.
//  - jedro_1 data port: stb/we/addr/wdata -> rdata/ack/err.
//  - Caravel Wishbone slave window, i.e. the dram slice of wishbone_mux.

---
 rtl/dram_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
// Shares the single-port data SRAM between the jedro_1 CPU data port and the
// Caravel Wishbone slave window. Round-robin grant; one RAM access in flight.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   cpu_stb_i/we_i/addr_i/wdata_i  CPU request (we_i = byte enables, 0 = read)
//   cpu_rdata_o/ack_o/err_o      CPU response (err = out-of-window)
//   wbs_stb_i/cyc_i/we_i/sel_i/dat_i/adr_i  Wishbone slave request
//   wbs_ack_o/dat_o              Wishbone response
//   ram_*                        SRAM port 0 (csb0/web0 active-low)
//   grant_o                      last granted requester: 0 = CPU, 1 = WB
//
// State table
//   state | meaning
//   IDLE  | arbitrate; register RAM command for the granted request
//   MEM   | RAM access cycle; release csb0/web0, arm the response pulse
//   RESP  | response pulse visible; read data passes through from ram_dout0
module dram_port_arbiter #(
    parameter int          RAM_ADDR_WIDTH_WORDS = 9,
    parameter logic [31:0] BASE_ADDR            = 32'h3000_8000
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic                            cpu_stb_i,
    input  logic [3:0]                      cpu_we_i,
    input  logic [31:0]                     cpu_addr_i,
    input  logic [31:0]                     cpu_wdata_i,
    output logic [31:0]                     cpu_rdata_o,
    output logic                            cpu_ack_o,
    output logic                            cpu_err_o,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_dat_i,
    input  logic [31:0]                     wbs_adr_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,
    output logic                            ram_clk0,
    output logic                            ram_csb0,
    output logic                            ram_web0,
    output logic [3:0]                      ram_wmask0,
    output logic [RAM_ADDR_WIDTH_WORDS-1:0] ram_addr0,
    output logic [31:0]                     ram_din0,
    input  logic [31:0]                     ram_dout0,
    output logic                            grant_o
);

    localparam int TAG_LSB = RAM_ADDR_WIDTH_WORDS + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        cur_wb;
    logic        cur_oow;

    logic        cpu_req;
    logic        wb_req;
    logic        pick_wb;
    logic [31:0] sel_addr;
    logic        sel_in_win;
    logic        sel_write;
    logic [3:0]  sel_mask;
    logic [31:0] sel_wdata;

    // Byte-offset bits never reach the word-addressed SRAM.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{cpu_addr_i[1:0], wbs_adr_i[1:0]};

    assign ram_clk0 = wb_clk_i;
    assign grant_o  = last_grant;

    assign cpu_req = cpu_stb_i;
    assign wb_req  = wbs_stb_i & wbs_cyc_i;

    // On a tie the requester that did not win last time gets the RAM.
    always_comb begin
        pick_wb = 1'b0;
        if (cpu_req && wb_req) begin
            pick_wb = ~last_grant;
        end else begin
            pick_wb = wb_req;
        end
    end

    assign sel_addr   = pick_wb ? wbs_adr_i : cpu_addr_i;
    assign sel_in_win = (sel_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign sel_write  = pick_wb ? wbs_we_i  : (cpu_we_i != 4'h0);
    assign sel_mask   = pick_wb ? wbs_sel_i : cpu_we_i;
    assign sel_wdata  = pick_wb ? wbs_dat_i : cpu_wdata_i;

    // SRAM read data is only exposed during the ack pulse; out-of-window
    // responses return zero.
    assign cpu_rdata_o = cpu_ack_o ? ram_dout0 : 32'h0;
    assign wbs_dat_o   = (wbs_ack_o && !cur_oow) ? ram_dout0 : 32'h0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cur_wb     <= 1'b0;
            cur_oow    <= 1'b0;
            ram_csb0   <= 1'b1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= 4'h0;
            ram_addr0  <= '0;
            ram_din0   <= 32'h0;
            cpu_ack_o  <= 1'b0;
            cpu_err_o  <= 1'b0;
            wbs_ack_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_ack_o <= 1'b0;
                    cpu_err_o <= 1'b0;
                    wbs_ack_o <= 1'b0;
                    if (cpu_req || wb_req) begin
                        last_grant <= pick_wb;
                        cur_wb     <= pick_wb;
                        cur_oow    <= ~sel_in_win;
                        if (sel_in_win) begin
                            ram_csb0   <= 1'b0;
                            ram_web0   <= ~sel_write;
                            ram_wmask0 <= sel_write ? sel_mask : 4'h0;
                            ram_addr0  <= sel_addr[TAG_LSB-1:2];
                            ram_din0   <= sel_wdata;
                        end
                        // Out-of-window requests also pass through MEM (with
                        // csb0 held high) so err/ack latency is uniform.
                        state <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    ram_csb0 <= 1'b1;
                    ram_web0 <= 1'b1;
                    if (cur_wb) begin
                        wbs_ack_o <= 1'b1;
                    end else if (cur_oow) begin
                        cpu_err_o <= 1'b1;
                    end else begin
                        cpu_ack_o <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_ack_o <= 1'b0;
                    cpu_err_o <= 1'b0;
                    wbs_ack_o <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
